// File: rtl/ides4_ddr_if.sv
// Data-side signals of the 1:4 DDR input deserializer.
// The serial source drives D/CALIB; the fabric consumes the parallel word and its strobe.
interface ides4_ddr_if;
    logic       D;
    logic       CALIB;
    logic [3:0] Q;
    logic       Q_VALID;

    modport master (
        output D,
        output CALIB,
        input  Q,
        input  Q_VALID
    );

    modport slave (
        input  D,
        input  CALIB,
        output Q,
        output Q_VALID
    );
endinterface

// File: rtl/ides_negcap.sv
// One-bit falling-edge capture flop with asynchronous active-low clear.
// It provides the earlier bit of each DDR pair.
module ides_negcap (
    input  logic CLK,
    input  logic CLEARN,
    input  logic D,
    output logic Q
);
    always_ff @(negedge CLK or negedge CLEARN) begin
        if (!CLEARN) begin
            Q <= 1'b0;
        end else begin
            Q <= D;
        end
    end
endmodule

// File: rtl/ides4_ddr.sv
// 1:4 DDR input deserializer: two bits per CLK cycle, one 4-bit word every two cycles.
// CALIB rising edges slip the word boundary one bit later.
module ides4_ddr #(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic        CLK,
    input  logic        CLEARN,
    ides4_ddr_if.slave  bus
);
    localparam int WIN0_HI = 5;
    localparam int WIN1_HI = 4;

    logic       dn;
    // Only sr[5:3] is ever read again; older history never reaches either window.
    logic [5:3] sr_reg;
    logic [5:1] sr_next;
    logic       ph_reg, ph_next;
    logic       sel_reg, sel_next;
    logic       calib_q_reg;
    logic       calib_rise;
    logic       emit;
    logic [3:0] win;
    logic [3:0] word;
    logic [3:0] q_reg;
    logic       q_valid_reg;

    ides_negcap u_negcap (
        .CLK    (CLK),
        .CLEARN (CLEARN),
        .D      (bus.D),
        .Q      (dn)
    );

    assign sr_next    = {bus.D, dn, sr_reg[5:3]};
    assign calib_rise = bus.CALIB & ~calib_q_reg;

    always_comb begin
        sel_next = sel_reg;
        ph_next  = ~ph_reg;
        emit     = ph_reg;
        if (calib_rise) begin
            if (!sel_reg) begin
                // Widening slip: hold the phase so the next word waits one extra cycle.
                sel_next = 1'b1;
                ph_next  = ph_reg;
                emit     = 1'b0;
            end else begin
                sel_next = 1'b0;
            end
        end
    end

    // The window follows the post-slip selection so a 1->0 slip can emit on the same edge.
    assign win = sel_next ? sr_next[WIN1_HI -: 4] : sr_next[WIN0_HI -: 4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_order
            assign word[gi] = LSB_FIRST ? win[gi] : win[3 - gi];
        end
    endgenerate

    always_ff @(posedge CLK or negedge CLEARN) begin
        if (!CLEARN) begin
            sr_reg      <= '0;
            ph_reg      <= 1'b0;
            sel_reg     <= 1'b0;
            calib_q_reg <= 1'b0;
            q_reg       <= 4'b0000;
            q_valid_reg <= 1'b0;
        end else begin
            sr_reg      <= sr_next[5:3];
            ph_reg      <= ph_next;
            sel_reg     <= sel_next;
            calib_q_reg <= bus.CALIB;
            q_valid_reg <= emit;
            if (emit) begin
                q_reg <= word;
            end
        end
    end

    assign bus.Q       = q_reg;
    assign bus.Q_VALID = q_valid_reg;
endmodule

// File: tb/tb_ides4_ddr.sv
// Directed bench for ides4_ddr: reset, cadence, bitslip, held CALIB, mid-stream reset, MSB-first order.
module tb_ides4_ddr;
    logic CLK    = 1'b0;
    logic CLEARN = 1'b0;

    always #5 CLK = ~CLK;

    ides4_ddr_if bus1 ();
    ides4_ddr_if bus2 ();

    ides4_ddr #(.LSB_FIRST(1'b1)) dut1 (
        .CLK    (CLK),
        .CLEARN (CLEARN),
        .bus    (bus1.slave)
    );

    ides4_ddr #(.LSB_FIRST(1'b0)) dut2 (
        .CLK    (CLK),
        .CLEARN (CLEARN),
        .bus    (bus2.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Edges 1..30 after release, one-hot stream 1,0,0,0 with slips at 6,10,14,18 and CALIB held 21..26.
    int t_cal [30] = '{0,0,0,0,0,1,0,0,0,1, 0,0,0,1,0,0,0,1,0,0, 1,1,1,1,1,1,0,0,0,0};
    int t_qv  [30] = '{0,1,0,1,0,0,1,0,1,0, 1,0,1,0,0,1,0,1,0,1, 0,0,1,0,1,0,1,0,1,0};
    int t_q   [30] = '{0,1,0,1,0,0,8,0,8,0, 4,0,4,0,0,2,0,1,0,1, 0,0,8,0,8,0,8,0,8,0};

    // Edges 1..8 after release, stream 1,1,0,1 with one slip at edge 6.
    int t6_cal [8] = '{0,0,0,0,0,1,0,0};
    int t6_qv  [8] = '{0,1,0,1,0,0,1,0};
    int t6_q1  [8] = '{0,4'hB,0,4'hB,0,0,4'hD,0};
    int t6_q2  [8] = '{0,4'hD,0,4'hD,0,0,4'hB,0};

    task automatic check(input string tag, input int idx, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s[%0d] observed=%h expected=%h", tag, idx, obs, exp);
        end
    endtask

    // Called at posedge+1; drives the early bit before the falling edge, the late bit before the rising edge.
    task automatic step(input logic n, input logic p, input logic c);
        bus1.D     = n;
        bus2.D     = n;
        bus1.CALIB = c;
        bus2.CALIB = c;
        @(negedge CLK);
        #1;
        bus1.D = p;
        bus2.D = p;
        @(posedge CLK);
        #1;
    endtask

    task automatic run_onehot(input string tag, input int n_edges);
        for (int i = 0; i < n_edges; i++) begin
            step((i % 2) == 0, 1'b0, t_cal[i] != 0);
            check({tag, "_qv"}, i + 1, {3'b000, bus1.Q_VALID}, 4'(t_qv[i]));
            if (t_qv[i] != 0)
                check({tag, "_q"}, i + 1, bus1.Q, 4'(t_q[i]));
        end
    endtask

    logic [3:0] pat;

    initial begin
        bus1.D = 1'b0; bus1.CALIB = 1'b0;
        bus2.D = 1'b0; bus2.CALIB = 1'b0;
        #2;
        check("rst_q", 0, bus1.Q, 4'h0);
        check("rst_qv", 0, {3'b000, bus1.Q_VALID}, 4'h0);

        @(posedge CLK);
        #1;
        step(1'b1, 1'b1, 1'b0);
        check("rst_hold_qv", 0, {3'b000, bus1.Q_VALID}, 4'h0);

        // Constant ones: strobes on even edges, all-ones word.
        CLEARN = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step(1'b1, 1'b1, 1'b0);
            check("ones_qv", k, {3'b000, bus1.Q_VALID}, (k % 2 == 0) ? 4'h1 : 4'h0);
        end
        check("ones_q", 4, bus1.Q, 4'hF);

        // Asynchronous clear between edges while a word is showing.
        #1;
        CLEARN = 1'b0;
        #1;
        check("aclr_q", 0, bus1.Q, 4'h0);
        check("aclr_qv", 0, {3'b000, bus1.Q_VALID}, 4'h0);
        @(posedge CLK);
        #1;
        step(1'b0, 1'b0, 1'b0);

        CLEARN = 1'b1;
        run_onehot("slip", 30);

        // Mid-stream reset with sel=1 and ph=1: alignment and cadence must start over.
        CLEARN = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        CLEARN = 1'b1;
        run_onehot("rerst", 5);

        CLEARN = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        CLEARN = 1'b1;
        pat = 4'b1011;
        for (int i = 0; i < 8; i++) begin
            step(pat[(2 * i) % 4], pat[(2 * i + 1) % 4], t6_cal[i] != 0);
            check("msb_qv", i + 1, {3'b000, bus2.Q_VALID}, 4'(t6_qv[i]));
            if (t6_qv[i] != 0) begin
                check("lsb_q", i + 1, bus1.Q, 4'(t6_q1[i]));
                check("msb_q", i + 1, bus2.Q, 4'(t6_q2[i]));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ides4_ddr.md
Name: ides4_ddr

Overview:
Single-clock 1:4 DDR input deserializer primitive for the Gowin simulation library. It captures serial data on both CLK edges, two bits per CLK cycle. It emits one 4-bit parallel word every two CLK cycles, with a one-cycle valid strobe. A CALIB bitslip input realigns word boundaries one bit at a time. It sits directly downstream of the falling-edge capture flops on the input path and feeds parallel fabric logic.

Parameters:
LSB_FIRST, 1, 1: earliest-received bit of each word lands on Q[0]; 0: earliest bit lands on Q[3].

Ports:
CLK  input  1  single clock; D sampled on both edges; all other state updates on rising edge.
CLEARN  input  1  asynchronous reset, active-low.
D  input  1  serial DDR data.
CALIB  input  1  bitslip request; level input, acted on at its 0->1 transition.
Q  output  4  parallel word, registered.
Q_VALID  output  1  one-cycle strobe; Q holds a new word.

Behaviour:
- Reset (CLEARN low, asynchronous, no clock needed) clears all of the following:
  - dn (falling-edge capture), sr[5:0], ph, sel, calib_q.
  - Q=4'b0000, Q_VALID=0.
- Deassertion takes effect at the next rising edge with CLEARN high.
- Falling edge: dn <= D.
- Rising edge k:
  - Pair (n_k=dn, p_k=D); n_k precedes p_k in time.
  - sr_nxt = {D, dn, sr[5:2]}; sr <= sr_nxt. sr[5] is newest, sr[0] oldest.
- Window:
  - sel=0: W = sr_nxt[5:2].
  - sel=1: W = sr_nxt[4:1] (ends one bit earlier).
  - W[0] is the earliest bit.
  - LSB_FIRST=1: Q gets W as-is.
  - LSB_FIRST=0: Q gets bit-reversed W.
- Calib edge: calib_rise = CALIB & ~calib_q; calib_q <= CALIB every rising edge.
- Normal edge (no calib_rise):
  - ph <= ~ph.
  - If ph==1: Q <= W, Q_VALID <= 1. Otherwise Q holds and Q_VALID <= 0.
- calib_rise with sel==0:
  - sel <= 1; ph holds.
  - No emission on this edge: Q holds, Q_VALID <= 0.
  - Net effect: next word is delayed one CLK cycle and its boundary is one bit later.
- calib_rise with sel==1:
  - sel <= 0; ph toggles normally.
  - If ph==1, emit on this edge using the new sel (window sr_nxt[5:2]).
  - Net effect: boundary is one bit later with no cadence change.
- Four successive slips return to the original alignment (boundary shifted by 4 bits, i.e. one word).
- CALIB held high slips exactly once; a new slip needs CALIB to go low for at least one rising edge.
- Cadence:
  - First Q_VALID is on the 2nd rising edge after reset release (CLEARN sampled high).
  - After that, Q_VALID pattern is 1,0,1,0...; Q_VALID is never high on two consecutive edges.
  - Max gap between strobes is 3 cycles (after a sel 0->1 slip).
- Partial data after reset: sr bits not yet filled are 0; those words are emitted as-is with no suppression.
- Latency: the bit sampled at rising edge k appears on Q after edge k if ph==1, else after edge k+1.
- Reset mid-word discards the partial word; sel returns to 0 (alignment lost).

Decomposition:
- No shared package; sel/ph are 1-bit, no typedefs needed.
- localparam WIN0_HI=5, WIN1_HI=4 local to the module.
- One natural sub-module: ides_negcap, a 1-bit falling-edge capture flop with async active-low clear (ports CLK, CLEARN, D, Q).
- Window mux, bit-reverse, ph/sel/calib FSM, and output registers stay in ides4_ddr.

Test Plan:
1. Drive CLEARN=0 between clock edges while Q=4'hF, Q_VALID=1 -> Q=4'h0 and Q_VALID=0 immediately, with no clock edge needed.
2. Release reset; hold D=1 constantly -> Q_VALID=1 at rising edges 2,4,6...; Q=4'hF by the second strobe; Q_VALID low on odd edges.
3. Send a period-4 one-hot stream 1,0,0,0 repeating (LSB_FIRST=1) -> constant Q from {0001,0010,0100,1000}. Then apply single-cycle CALIB pulses spaced 4 cycles apart:
   - Each pulse rotates Q right by one, e.g. 0100 -> 0010 -> 0001 -> 1000 -> 0100.
   - The 1st and 3rd pulses (sel 0->1) produce a 3-cycle strobe gap.
4. Hold CALIB=1 for 6 cycles with the one-hot stream -> exactly one rotation; Q stable afterwards.
5. Assert CLEARN low mid-stream after 2 slips -> sel=0; after release, first strobe at rising edge 2; alignment matches the post-reset alignment from test 3.
6. Set LSB_FIRST=0 and send the stream 1,1,0,1 repeating (aligned via CALIB) -> Q=4'b1011 when LSB_FIRST=1 would give 4'b1011 bit-reversed, i.e. Q=4'b1101.
